// File: rtl/tx_ingress_pkg.sv
// Shared definitions for the TX ingress slice: FSM encodings, control word
// indices and the layout of the 52-bit control FIFO entry.
package tx_ingress_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CTRL = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int CTRL_W_FLAG   = 0;
  localparam int CTRL_W_CSCTRL = 1;
  localparam int CTRL_W_CSPOS  = 2;
  localparam int CTRL_W_CSINIT = 3;

  localparam int CF_WIDTH     = 52;
  localparam int CF_CSUM_LSB  = 0;
  localparam int CF_INS_LSB   = 16;
  localparam int CF_LEN_LSB   = 32;
  localparam int CF_FLAG_LSB  = 48;

  typedef struct packed {
    logic [3:0]  flag;
    logic [15:0] len;
    logic [15:0] cs_insert;
    logic [15:0] csum;
  } ctrl_entry_t;

  // End-around carry: one fold plus the carry of that fold always fits 16 bits.
  function automatic logic [15:0] csum_fold(input logic [31:0] acc);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/tx_csum_accum.sv
// One's-complement checksum accumulator over big-endian byte pairs of a frame,
// built only when TX_INGRESS_CSUM_EN is defined.
module tx_csum_accum
  import tx_ingress_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      seed_i,
  input  logic [15:0]               seed_val_i,
  input  logic                      beat_i,
  input  logic [C_DATA_WIDTH-1:0]   tdata_i,
  input  logic [C_DATA_WIDTH/8-1:0] tkeep_i,
  input  logic [C_LEN_WIDTH-1:0]    beat_off_i,
  input  logic [15:0]               cs_begin_i,
  output logic [15:0]               csum_o
);

  localparam int KW = C_DATA_WIDTH / 8;

  logic [KW-1:0] lane_en;
  logic [31:0]   beat_sum;
  logic [31:0]   acc_q;

  // Even frame offsets are the high byte of a pair; a missing odd partner adds 0.
  always_comb begin
    lane_en  = '0;
    beat_sum = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      lane_en[i] = tkeep_i[i] && ((32'(beat_off_i) + i) >= 32'(cs_begin_i));
      if (lane_en[i]) begin
        if (beat_off_i[0] ^ i[0])
          beat_sum = beat_sum + {24'b0, tdata_i[8*i +: 8]};
        else
          beat_sum = beat_sum + {16'b0, tdata_i[8*i +: 8], 8'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        acc_q <= '0;
    else if (seed_i)  acc_q <= {16'b0, seed_val_i};
    else if (beat_i)  acc_q <= acc_q + beat_sum;
  end

  assign csum_o = csum_fold(acc_q);

endmodule

// File: rtl/tx_ingress_fsm.sv
// TX ingress sequencer: captures txc control words, forwards txd beats into the
// data FIFO and writes one control FIFO entry per frame. TX_INGRESS_CSUM_EN adds checksum.
module tx_ingress_fsm
  import tx_ingress_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_CTRL_WORDS = 6,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                                 mm2s_clk,
  input  logic                                 mm2s_reset,
  input  logic [31:0]                          txc_tdata,
  input  logic [3:0]                           txc_tkeep,
  input  logic                                 txc_tvalid,
  input  logic                                 txc_tlast,
  output logic                                 txc_tready,
  input  logic [C_DATA_WIDTH-1:0]              txd_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]            txd_tkeep,
  input  logic                                 txd_tvalid,
  input  logic                                 txd_tlast,
  output logic                                 txd_tready,
  input  logic                                 ctrl_fifo_afull,
  output logic                                 ctrl_fifo_wren,
  output logic [CF_WIDTH-1:0]                  ctrl_fifo_wdata,
  input  logic                                 data_fifo_afull,
  output logic                                 data_fifo_wren,
  output logic [C_DATA_WIDTH+C_DATA_WIDTH/8:0] data_fifo_wdata,
  output logic [3:0]                           fsm_dbg
);

  localparam int KW = C_DATA_WIDTH / 8;
  localparam int CW = $clog2(KW) + 1;

  logic [2:0]             state_q, state_d;
  logic                   ctrl_afull_q, data_afull_q;
  logic [2:0]             ctrl_idx_q;
  logic [3:0]             flag_q;
  logic [1:0]             cs_ctrl_q;
  logic [15:0]            cs_begin_q, cs_insert_q, cs_init_q;
  logic [C_LEN_WIDTH-1:0] len_q;
  logic                   data_wren_q, ctrl_wren_q;
  logic [KW+C_DATA_WIDTH:0] data_wdata_q;
  ctrl_entry_t            ctrl_wdata_q;
  logic [CW-1:0]          beat_bytes;
  logic [15:0]            csum_w;
  logic                   txc_hs, txd_hs, frame_start, data_start;

  assign txc_tready  = (state_q == ST_CTRL);
  assign txd_tready  = (state_q == ST_DATA) && !data_afull_q;
  assign txc_hs      = txc_tvalid && txc_tready;
  assign txd_hs      = txd_tvalid && txd_tready;
  assign frame_start = (state_q == ST_IDLE) && (state_d == ST_CTRL);
  assign data_start  = (state_q == ST_WAIT) && (state_d == ST_DATA);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (txc_tvalid && !ctrl_afull_q) state_d = ST_CTRL;
      ST_CTRL: if (txc_hs && txc_tlast)         state_d = ST_WAIT;
      ST_WAIT: if (txd_tvalid && !data_afull_q) state_d = ST_DATA;
      ST_DATA: if (txd_hs && txd_tlast)         state_d = ST_DONE;
      ST_DONE:                                  state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KW; i++) beat_bytes = beat_bytes + CW'(txd_tkeep[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mm2s_clk) begin
    if (mm2s_reset) begin
      state_q      <= ST_IDLE;
      ctrl_afull_q <= 1'b1;
      data_afull_q <= 1'b1;
      ctrl_idx_q   <= '0;
      flag_q       <= '0;
      cs_ctrl_q    <= '0;
      cs_begin_q   <= '0;
      cs_insert_q  <= '0;
      cs_init_q    <= '0;
      len_q        <= '0;
      data_wren_q  <= 1'b0;
      ctrl_wren_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_afull_q <= ctrl_fifo_afull;
      data_afull_q <= data_fifo_afull;
      data_wren_q  <= txd_hs;
      ctrl_wren_q  <= (state_q == ST_DONE);
      if (frame_start) begin
        ctrl_idx_q  <= '0;
        flag_q      <= '0;
        cs_ctrl_q   <= '0;
        cs_begin_q  <= '0;
        cs_insert_q <= '0;
        cs_init_q   <= '0;
        len_q       <= '0;
      end else if (txc_hs) begin
        case (ctrl_idx_q)
          3'(CTRL_W_FLAG):   flag_q    <= txc_tdata[31:28];
          3'(CTRL_W_CSCTRL): cs_ctrl_q <= txc_tdata[1:0];
          3'(CTRL_W_CSPOS): begin
            cs_begin_q  <= txc_tdata[31:16];
            cs_insert_q <= txc_tdata[15:0];
          end
          3'(CTRL_W_CSINIT): cs_init_q <= txc_tdata[15:0];
          default: ;
        endcase
        if (ctrl_idx_q != 3'(C_CTRL_WORDS - 1)) ctrl_idx_q <= ctrl_idx_q + 3'd1;
      end else if (txd_hs) begin
        len_q <= len_q + C_LEN_WIDTH'(beat_bytes);
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed when their wren is high.
  always_ff @(posedge mm2s_clk) begin
    if (txd_hs)              data_wdata_q <= {txd_tlast, txd_tkeep, txd_tdata};
    if (state_q == ST_DONE)  ctrl_wdata_q <= '{flag_q, 16'(len_q), cs_insert_q, csum_w};
  end

`ifdef TX_INGRESS_CSUM_EN
  logic [15:0] sum_fold;

  tx_csum_accum #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_LEN_WIDTH  (C_LEN_WIDTH)
  ) u_csum (
    .clk_i      (mm2s_clk),
    .rst_i      (mm2s_reset),
    .seed_i     (data_start),
    .seed_val_i (cs_init_q),
    .beat_i     (txd_hs),
    .tdata_i    (txd_tdata),
    .tkeep_i    (txd_tkeep),
    .beat_off_i (len_q),
    .cs_begin_i (cs_begin_q),
    .csum_o     (sum_fold)
  );

  assign csum_w = (cs_ctrl_q == 2'd0) ? cs_init_q : sum_fold;

  logic unused_ok;
  assign unused_ok = ^txc_tkeep;
`else
  assign csum_w = cs_init_q;

  logic unused_ok;
  assign unused_ok = ^{txc_tkeep, cs_begin_q, cs_ctrl_q, data_start};
`endif

  assign ctrl_fifo_wren  = ctrl_wren_q;
  assign ctrl_fifo_wdata = ctrl_wdata_q;
  assign data_fifo_wren  = data_wren_q;
  assign data_fifo_wdata = data_wdata_q;
  assign fsm_dbg         = {1'b0, state_q};

endmodule

// File: tb/tb_tx_ingress_fsm.sv
// Directed bench for tx_ingress_fsm; checksum expectations follow TX_INGRESS_CSUM_EN.
module tb_tx_ingress_fsm;

  logic        clk;
  logic        mm2s_reset;
  logic [31:0] txc_tdata;
  logic [3:0]  txc_tkeep;
  logic        txc_tvalid, txc_tlast, txc_tready;
  logic [63:0] txd_tdata;
  logic [7:0]  txd_tkeep;
  logic        txd_tvalid, txd_tlast, txd_tready;
  logic        ctrl_fifo_afull, ctrl_fifo_wren;
  logic [51:0] ctrl_fifo_wdata;
  logic        data_fifo_afull, data_fifo_wren;
  logic [72:0] data_fifo_wdata;
  logic [3:0]  fsm_dbg;

`ifdef TX_INGRESS_CSUM_EN
  localparam logic [15:0] EXP_CS_RUNT = 16'h242A;
  localparam logic [15:0] EXP_CS_IP   = 16'h0783;
`else
  localparam logic [15:0] EXP_CS_RUNT = 16'h0000;
  localparam logic [15:0] EXP_CS_IP   = 16'h0000;
`endif

  tx_ingress_fsm dut (
    .mm2s_clk        (clk),
    .mm2s_reset      (mm2s_reset),
    .txc_tdata       (txc_tdata),
    .txc_tkeep       (txc_tkeep),
    .txc_tvalid      (txc_tvalid),
    .txc_tlast       (txc_tlast),
    .txc_tready      (txc_tready),
    .txd_tdata       (txd_tdata),
    .txd_tkeep       (txd_tkeep),
    .txd_tvalid      (txd_tvalid),
    .txd_tlast       (txd_tlast),
    .txd_tready      (txd_tready),
    .ctrl_fifo_afull (ctrl_fifo_afull),
    .ctrl_fifo_wren  (ctrl_fifo_wren),
    .ctrl_fifo_wdata (ctrl_fifo_wdata),
    .data_fifo_afull (data_fifo_afull),
    .data_fifo_wren  (data_fifo_wren),
    .data_fifo_wdata (data_fifo_wdata),
    .fsm_dbg         (fsm_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs_cyc = 0;
  int low_cnt = 0;
  logic prev_rdy = 1'b0;
  logic [51:0] ctrl_q[$];
  int          ctrl_cyc_q[$];
  logic [72:0] data_q[$];
  int          data_cyc_q[$];
  int          rise_q[$];

  always @(posedge clk) cyc = cyc + 1;

  // FIFO-side observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (ctrl_fifo_wren === 1'b1) begin
      ctrl_q.push_back(ctrl_fifo_wdata);
      ctrl_cyc_q.push_back(cyc);
    end
    if (data_fifo_wren === 1'b1) begin
      data_q.push_back(data_fifo_wdata);
      data_cyc_q.push_back(cyc);
    end
    if (txd_tvalid && txd_tready === 1'b1 && txd_tlast) last_hs_cyc = cyc;
    if (txc_tready === 1'b1 && prev_rdy !== 1'b1) rise_q.push_back(cyc);
    prev_rdy = txc_tready;
    if (fsm_dbg === 4'd3 && txd_tready === 1'b0) low_cnt++;
  end

  task automatic clear_obs();
    ctrl_q.delete(); ctrl_cyc_q.delete(); data_q.delete(); data_cyc_q.delete(); rise_q.delete();
  endtask

  task automatic send_ctrl(input logic [7:0][31:0] w, input int n, input bit hold);
    int t;
    for (int i = 0; i < n; i++) begin
      txc_tdata  = w[i];
      txc_tlast  = (i == n - 1);
      txc_tvalid = 1'b1;
      t = 0;
      while (txc_tready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        total++; bad++;
        $display("FAIL ctrl_timeout: word %0d never accepted, txc_tready=%b required 1", i, txc_tready);
        break;
      end
      @(posedge clk); #1;
    end
    if (!hold) begin txc_tvalid = 1'b0; txc_tlast = 1'b0; end
  endtask

  task automatic send_data(input logic [3:0][63:0] d, input logic [3:0][7:0] k, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      txd_tdata  = d[i];
      txd_tkeep  = k[i];
      txd_tlast  = (i == n - 1);
      txd_tvalid = 1'b1;
      t = 0;
      while (txd_tready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        total++; bad++;
        $display("FAIL data_timeout: beat %0d never accepted, txd_tready=%b required 1", i, txd_tready);
        break;
      end
      @(posedge clk); #1;
    end
    txd_tvalid = 1'b0; txd_tlast = 1'b0;
  endtask

  task automatic wait_ctrl(input int n);
    int t = 0;
    while (ctrl_q.size() < n && t < 40) begin @(negedge clk); t++; end
    if (ctrl_q.size() < n) begin
      total++; bad++;
      $display("FAIL ctrl_wait: got %0d entries required %0d", ctrl_q.size(), n);
    end
  endtask

  task automatic test_reset();
    int c0, t;
    mm2s_reset = 1'b1;
    txc_tvalid = 1'b1; txc_tdata = 32'hA000_0000; txc_tlast = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++; if (fsm_dbg !== 4'd0) begin bad++; $display("FAIL rst_state: got %h required 0", fsm_dbg); end
    total++; if (txc_tready !== 1'b0) begin bad++; $display("FAIL rst_txc_tready: got %b required 0", txc_tready); end
    total++; if (txd_tready !== 1'b0) begin bad++; $display("FAIL rst_txd_tready: got %b required 0", txd_tready); end
    total++; if (ctrl_fifo_wren !== 1'b0) begin bad++; $display("FAIL rst_ctrl_wren: got %b required 0", ctrl_fifo_wren); end
    total++; if (data_fifo_wren !== 1'b0) begin bad++; $display("FAIL rst_data_wren: got %b required 0", data_fifo_wren); end
    mm2s_reset = 1'b0;
    c0 = cyc;
    t = 0;
    while (txc_tready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    // afull register comes out of reset high, so IDLE waits one extra cycle.
    total++; if (cyc !== c0 + 2) begin bad++; $display("FAIL rst_afull_start: txc_tready at cycle %0d required %0d", cyc, c0 + 2); end
  endtask

  task automatic test_basic();
    logic [7:0][31:0] w = '0;
    logic [3:0][63:0] d = '0;
    logic [3:0][7:0]  k = '0;
    clear_obs();
    w[0] = 32'hA000_0000; w[1] = 32'h1; w[2] = 32'h000E_0032; w[3] = 32'h0;
    d[0] = 64'h0011_2233_4455_6677; k[0] = 8'hFF;
    send_ctrl(w, 4, 1'b0);
    send_data(d, k, 1);
    wait_ctrl(1);
    total++; if (data_q.size() !== 1) begin bad++; $display("FAIL basic_data_cnt: got %0d required 1", data_q.size()); end
    if (data_q.size() >= 1) begin
      total++; if (data_q[0] !== {1'b1, 8'hFF, 64'h0011_2233_4455_6677}) begin bad++; $display("FAIL basic_data: got %h", data_q[0]); end
      total++; if (data_cyc_q[0] !== last_hs_cyc + 1) begin bad++; $display("FAIL basic_data_lat: got %0d required %0d", data_cyc_q[0], last_hs_cyc + 1); end
    end
    if (ctrl_q.size() >= 1) begin
      total++; if (ctrl_q[0] !== {4'hA, 16'd8, 16'h0032, 16'h0000}) begin bad++; $display("FAIL basic_ctrl: got %h required %h", ctrl_q[0], {4'hA, 16'd8, 16'h0032, 16'h0000}); end
      total++; if (ctrl_cyc_q[0] !== last_hs_cyc + 2) begin bad++; $display("FAIL basic_ctrl_lat: got %0d required %0d", ctrl_cyc_q[0], last_hs_cyc + 2); end
    end
  endtask

  task automatic test_runt();
    logic [7:0][31:0] w = '0;
    logic [3:0][63:0] d = '0;
    logic [3:0][7:0]  k = '0;
    clear_obs();
    w[0] = 32'h5000_0000; w[1] = 32'h1;
    d[0] = 64'h0807_0605_0403_0201; k[0] = 8'hFF;
    d[1] = 64'hFFFF_FFFF_0C0B_0A09; k[1] = 8'h0F;
    send_ctrl(w, 2, 1'b0);
    send_data(d, k, 2);
    wait_ctrl(1);
    total++; if (data_q.size() !== 2) begin bad++; $display("FAIL runt_data_cnt: got %0d required 2", data_q.size()); end
    if (data_q.size() >= 2) begin
      total++; if (data_q[1] !== {1'b1, 8'h0F, 64'hFFFF_FFFF_0C0B_0A09}) begin bad++; $display("FAIL runt_data1: got %h", data_q[1]); end
    end
    if (ctrl_q.size() >= 1) begin
      total++; if (ctrl_q[0] !== {4'h5, 16'd12, 16'h0000, EXP_CS_RUNT}) begin bad++; $display("FAIL runt_ctrl: got %h required %h", ctrl_q[0], {4'h5, 16'd12, 16'h0000, EXP_CS_RUNT}); end
    end
  endtask

  task automatic test_afull();
    logic [7:0][31:0] w = '0;
    logic [3:0][63:0] d = '0;
    logic [3:0][7:0]  k = '0;
    clear_obs();
    w[0] = 32'h3000_0000; w[1] = 32'h0; w[2] = 32'h0000_0055; w[3] = 32'h0000_1234;
    w[4] = 32'hDEAD_BEEF; w[5] = 32'hDEAD_BEEF; w[6] = 32'hDEAD_BEEF;
    d[0] = 64'h1111_1111_1111_1111; k[0] = 8'hFF;
    d[1] = 64'h2222_2222_2222_2222; k[1] = 8'hFF;
    d[2] = 64'h3333_3333_3333_3333; k[2] = 8'hFF;
    d[3] = 64'h4444_4444_4444_4444; k[3] = 8'h07;
    send_ctrl(w, 7, 1'b0);
    low_cnt = 0;
    fork
      send_data(d, k, 4);
      begin : afull_drv
        int t = 0;
        while (fsm_dbg !== 4'd3 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        data_fifo_afull = 1'b1;
        @(negedge clk);
        total++; if (txd_tready !== 1'b1) begin bad++; $display("FAIL afull_reg_latency: txd_tready=%b required 1", txd_tready); end
        repeat (5) @(posedge clk); #1;
        data_fifo_afull = 1'b0;
      end
    join
    wait_ctrl(1);
    total++; if (low_cnt !== 5) begin bad++; $display("FAIL afull_low_cycles: got %0d required 5", low_cnt); end
    total++; if (data_q.size() !== 4) begin bad++; $display("FAIL afull_data_cnt: got %0d required 4", data_q.size()); end
    for (int i = 0; i < 4 && i < data_q.size(); i++) begin
      total++;
      if (data_q[i] !== {(i == 3), k[i], d[i]}) begin bad++; $display("FAIL afull_data%0d: got %h required %h", i, data_q[i], {(i == 3), k[i], d[i]}); end
    end
    if (ctrl_q.size() >= 1) begin
      total++; if (ctrl_q[0] !== {4'h3, 16'd27, 16'h0055, 16'h1234}) begin bad++; $display("FAIL afull_ctrl: got %h required %h", ctrl_q[0], {4'h3, 16'd27, 16'h0055, 16'h1234}); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0][31:0] w = '0;
    int nd, nc, t;
    clear_obs();
    w[0] = 32'h7000_0000; w[1] = 32'h1;
    send_ctrl(w, 4, 1'b0);
    txd_tdata = 64'h5555_5555_5555_5555; txd_tkeep = 8'hFF; txd_tlast = 1'b0; txd_tvalid = 1'b1;
    t = 0;
    while (txd_tready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    txd_tvalid = 1'b0;
    @(posedge clk); #1;
    total++; if (fsm_dbg !== 4'd3) begin bad++; $display("FAIL mid_in_data: got %h required 3", fsm_dbg); end
    nd = data_q.size();
    nc = ctrl_q.size();
    mm2s_reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (txd_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_tready: got %b required 0", txd_tready); end
    mm2s_reset = 1'b0;
    total++; if (fsm_dbg !== 4'd0) begin bad++; $display("FAIL mid_resume_idle: got %h required 0", fsm_dbg); end
    repeat (6) @(posedge clk); #1;
    total++; if (ctrl_q.size() !== nc) begin bad++; $display("FAIL mid_no_ctrl: got %0d entries required %0d", ctrl_q.size(), nc); end
    total++; if (data_q.size() !== nd) begin bad++; $display("FAIL mid_no_data: got %0d writes required %0d", data_q.size(), nd); end
  endtask

  task automatic test_csum_frame();
    logic [7:0][31:0] w = '0;
    logic [3:0][63:0] d = '0;
    logic [3:0][7:0]  k = '0;
    clear_obs();
    w[0] = 32'h1000_0000; w[1] = 32'h1; w[2] = 32'h0000_000A; w[3] = 32'h0;
    // Bytes 45 00 00 1c 00 01 00 00 40 11 00 00 c0 a8 00 01 c0 a8 00 02 01.
    d[0] = 64'h0000_0100_1C00_0045; k[0] = 8'hFF;
    d[1] = 64'h0100_A8C0_0000_1140; k[1] = 8'hFF;
    d[2] = 64'hEEEE_EE01_0200_A8C0; k[2] = 8'h1F;
    send_ctrl(w, 4, 1'b0);
    send_data(d, k, 3);
    wait_ctrl(1);
    total++; if (data_q.size() !== 3) begin bad++; $display("FAIL csum_data_cnt: got %0d required 3", data_q.size()); end
    if (ctrl_q.size() >= 1) begin
      total++; if (ctrl_q[0] !== {4'h1, 16'd21, 16'h000A, EXP_CS_IP}) begin bad++; $display("FAIL csum_ctrl: got %h required %h", ctrl_q[0], {4'h1, 16'd21, 16'h000A, EXP_CS_IP}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0][31:0] wf = '0;
    logic [7:0][31:0] wg = '0;
    logic [3:0][63:0] d = '0;
    logic [3:0][7:0]  k = '0;
    int hs_f;
    clear_obs();
    wf[0] = 32'h2000_0000; wf[2] = 32'h0000_0011; wf[3] = 32'h0000_BEEF;
    wg[0] = 32'h9000_0000; wg[2] = 32'h0000_0022; wg[3] = 32'h0000_00CA;
    send_ctrl(wf, 4, 1'b1);
    d[0] = 64'h0000_0000_0000_ABCD; k[0] = 8'h03;
    send_data(d, k, 1);
    hs_f = last_hs_cyc;
    send_ctrl(wg, 4, 1'b0);
    d[0] = 64'h0000_0000_0000_0077; k[0] = 8'h01;
    send_data(d, k, 1);
    wait_ctrl(2);
    total++; if (rise_q.size() !== 2) begin bad++; $display("FAIL b2b_rise_cnt: got %0d required 2", rise_q.size()); end
    if (rise_q.size() >= 2) begin
      total++; if (rise_q[1] !== hs_f + 3) begin bad++; $display("FAIL b2b_txc_tready: got cycle %0d required %0d", rise_q[1], hs_f + 3); end
    end
    if (ctrl_q.size() >= 2) begin
      total++; if (ctrl_q[0] !== {4'h2, 16'd2, 16'h0011, 16'hBEEF}) begin bad++; $display("FAIL b2b_ctrl0: got %h required %h", ctrl_q[0], {4'h2, 16'd2, 16'h0011, 16'hBEEF}); end
      total++; if (ctrl_q[1] !== {4'h9, 16'd1, 16'h0022, 16'h00CA}) begin bad++; $display("FAIL b2b_ctrl1: got %h required %h", ctrl_q[1], {4'h9, 16'd1, 16'h0022, 16'h00CA}); end
      total++; if (ctrl_cyc_q[0] !== hs_f + 2) begin bad++; $display("FAIL b2b_ctrl0_lat: got %0d required %0d", ctrl_cyc_q[0], hs_f + 2); end
    end
  endtask

  initial begin
    mm2s_reset = 1'b1;
    txc_tdata = '0; txc_tkeep = 4'hF; txc_tvalid = 1'b0; txc_tlast = 1'b0;
    txd_tdata = '0; txd_tkeep = '0;   txd_tvalid = 1'b0; txd_tlast = 1'b0;
    ctrl_fifo_afull = 1'b0; data_fifo_afull = 1'b0;
    test_reset();
    test_basic();
    test_runt();
    test_afull();
    test_reset_mid_frame();
    test_csum_frame();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
